// File: rtl/uart_baud_gen_frac_if.sv
// uart_baud_gen_frac_if: config/control inputs and tick outputs of the fractional baud generator
interface uart_baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR_W  = 5
);
  logic              en;
  logic              sync_restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [OSR_W-1:0]  osr;
  logic              tick_os;
  logic              tick_mid;
  logic              tick_bit;
  logic [OSR_W-1:0]  os_phase;
  logic              cfg_err;
  modport master (
    output en, sync_restart, div_int, div_frac, osr,
    input  tick_os, tick_mid, tick_bit, os_phase, cfg_err
  );
  modport slave (
    input  en, sync_restart, div_int, div_frac, osr,
    output tick_os, tick_mid, tick_bit, os_phase, cfg_err
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional-N oversample tick generator with mid-bit and bit-boundary pulses
module uart_baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR_W  = 5
) (
  input  logic clk,
  input  logic rst_n,
  uart_baud_gen_frac_if.slave bus
);
  logic [DIV_W:0]    r_cnt;
  logic [FRAC_W-1:0] r_acc, r_frac;
  logic [DIV_W-1:0]  r_div;
  logic [OSR_W-1:0]  r_osr, r_phase;
  logic              r_en_d, r_err, r_tick_os, r_tick_mid, r_tick_bit;
  logic [FRAC_W:0]   w_sum;
  logic [DIV_W:0]    w_period;
  logic              w_start, w_tick, w_last, w_bit, w_mid, w_cap, w_bad;
  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, r_frac};
    w_period = {1'b0, r_div} + {{DIV_W{1'b0}}, w_sum[FRAC_W]};
    w_start  = bus.en & (~r_en_d | bus.sync_restart);
    w_tick   = bus.en & ~w_start & ~r_err & (r_cnt == w_period - (DIV_W+1)'(1));
    w_last   = r_phase == r_osr - OSR_W'(1);
    w_bit    = w_tick & w_last;
    w_mid    = w_tick & (r_phase == (r_osr >> 1) - OSR_W'(1));
    w_cap    = w_start | w_bit;
    w_bad    = (bus.div_int < DIV_W'(2)) | (bus.osr < OSR_W'(4));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_div      <= '0;
      r_frac     <= '0;
      r_osr      <= '0;
      r_phase    <= '0;
      r_en_d     <= 1'b0;
      r_err      <= 1'b0;
      r_tick_os  <= 1'b0;
      r_tick_mid <= 1'b0;
      r_tick_bit <= 1'b0;
    end else begin
      r_en_d     <= bus.en;
      r_tick_os  <= w_tick;
      r_tick_mid <= w_mid;
      r_tick_bit <= w_bit;
      if (w_cap) begin
        r_div  <= bus.div_int;
        r_frac <= bus.div_frac;
        r_osr  <= bus.osr;
        r_err  <= w_bad;
      end
      // en rise counts as the first edge of a period; a restart edge does not
      if (!bus.en || (w_cap && w_bad)) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_phase <= '0;
      end else if (w_start) begin
        r_cnt   <= bus.sync_restart ? '0 : (DIV_W+1)'(1);
        r_acc   <= '0;
        r_phase <= '0;
      end else if (w_tick) begin
        r_cnt   <= '0;
        r_acc   <= w_sum[FRAC_W-1:0];
        r_phase <= w_last ? '0 : r_phase + OSR_W'(1);
      end else if (!r_err) begin
        r_cnt <= r_cnt + (DIV_W+1)'(1);
      end
    end
  end
  assign bus.tick_os  = r_tick_os;
  assign bus.tick_mid = r_tick_mid;
  assign bus.tick_bit = r_tick_bit;
  assign bus.os_phase = r_phase;
  assign bus.cfg_err  = r_err;
endmodule
